// File: rtl/fifo_rd_packer_pkg.sv
// Shared constants and state encodings for the FIFO read-side packer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_rd_packer_pkg;

  // Default geometry, shared with the async FIFO that feeds this block.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_PACK  = 4;

  // Packer states: collecting beats, full word waiting, partial word waiting.
  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_COMPLETE = 2'd1,
    ST_FLUSH    = 2'd2
  } pack_state_t;

endpackage

// File: rtl/fifo_out_reg.sv
// Single-entry valid/ready output register for packed words.
// Latency: word loaded at edge N is presented from edge N onward (1 register stage).
// Backpressure: holds data/keep stable while out_valid & ~out_ready; load may coincide with fire.
module fifo_out_reg #(
  parameter int DW = 32,
  parameter int KW = 3
) (
  input  logic          rd_clk,
  input  logic          res,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic [KW-1:0] load_keep,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [KW-1:0] out_keep,
  output logic          out_valid,
  output logic          fire
);

  assign fire = out_valid & out_ready;

  // Load replaces the held word (caller only loads when empty or firing); fire empties it.
  always_ff @(posedge rd_clk or posedge res) begin
    if (res) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_keep  <= load_keep;
      out_valid <= 1'b1;
    end else if (fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops beats from the async FIFO read side and packs PACK beats LSB-first into one word.
// Latency: beat popped at edge N lands at N+1; a completing beat is on out_valid at N+2.
// Backpressure: a full/flushed word waits in the packer until the output register frees; popping stops meanwhile.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PACK  = DEF_PACK,
  parameter int CNT_W = $clog2(PACK) + 1
) (
  input  logic                  rd_clk,
  input  logic                  res,
  input  logic                  empty,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  rd_en,
  input  logic                  flush,
  output logic [WIDTH*PACK-1:0] out_data,
  output logic [CNT_W-1:0]      out_keep,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           words_out
);

  localparam logic [CNT_W-1:0] PACK_C  = CNT_W'(PACK);
  localparam logic [CNT_W:0]   PACK_W1 = (CNT_W + 1)'(PACK);

  pack_state_t             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pend_q;
  logic [WIDTH*PACK-1:0]   pack_q, pack_d;
  logic                    room;
  logic                    flush_hold;
  logic                    xfer;
  logic                    fire;

  // Beats held plus the one in flight must leave space in the word.
  assign room = ({1'b0, cnt_q} + {{CNT_W{1'b0}}, pend_q}) < PACK_W1;

  // Stop popping once a flush can be honoured, and for as long as the partial word waits.
  assign flush_hold = (state_q == ST_FLUSH) |
                      ((state_q == ST_FILL) & flush & (cnt_q != '0) & ~pend_q);

  assign rd_en = ~res & ~empty & room & ~flush_hold;

  // Word leaves the packer when the output register is empty or being drained this cycle.
  assign xfer = (state_q != ST_FILL) & (~out_valid | out_ready);

  // Next-state: land the in-flight beat, detect complete/flush, clear on transfer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pack_d  = pack_q;
    case (state_q)
      ST_FILL: begin
        if (pend_q) begin
          for (int k = 0; k < PACK; k++) begin
            if (cnt_q == CNT_W'(k)) pack_d[k*WIDTH +: WIDTH] = rdata;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == PACK_C) state_d = ST_COMPLETE;
        end else if (flush && (cnt_q != '0)) begin
          state_d = ST_FLUSH;
        end
      end
      ST_COMPLETE, ST_FLUSH: begin
        if (xfer) begin
          state_d = ST_FILL;
          cnt_d   = '0;
          pack_d  = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Packer state, beat count, in-flight flag and pack register.
  always_ff @(posedge rd_clk or posedge res) begin
    if (res) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pack_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= rd_en;
      pack_q  <= pack_d;
    end
  end

  // Count delivered words; wraps naturally at 16 bits.
  always_ff @(posedge rd_clk or posedge res) begin
    if (res) words_out <= '0;
    else if (fire) words_out <= words_out + 16'd1;
  end

  fifo_out_reg #(
    .DW (WIDTH*PACK),
    .KW (CNT_W)
  ) u_out_reg (
    .rd_clk    (rd_clk),
    .res       (res),
    .load      (xfer),
    .load_data (pack_q),
    .load_keep (cnt_q),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .fire      (fire)
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a behavioural FIFO read side.
// Latency: n/a (testbench).
// Backpressure: out_ready driven per step; fired words captured on the falling edge.
module tb_fifo_rd_packer;

  logic        rd_clk;
  logic        res;
  logic        empty;
  logic [7:0]  rdata;
  logic        rd_en;
  logic        flush;
  logic [31:0] out_data;
  logic [2:0]  out_keep;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] words_out;

  int tests;
  int failed;
  int underflow;

  logic [7:0]  wq[$];
  logic [7:0]  fq[$];
  logic [31:0] got_dat[$];
  logic [2:0]  got_keep[$];

  fifo_rd_packer #(.WIDTH(8), .PACK(4)) dut (
    .rd_clk    (rd_clk),
    .res       (res),
    .empty     (empty),
    .rdata     (rdata),
    .rd_en     (rd_en),
    .flush     (flush),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .words_out (words_out)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // FIFO read side: pop on rd_en, data valid next cycle; written beats appear after one edge.
  always @(posedge rd_clk) begin
    if (rd_en) begin
      if (fq.size() == 0) underflow++;
      else rdata <= fq.pop_front();
    end
    while (wq.size() > 0) fq.push_back(wq.pop_front());
    empty <= (fq.size() == 0);
  end

  // Record each word that will fire on the coming rising edge.
  always @(negedge rd_clk) begin
    if (!res && out_valid && out_ready) begin
      got_dat.push_back(out_data);
      got_keep.push_back(out_keep);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wq.push_back(b);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (got_dat.size() < n && c < budget) begin
      @(posedge rd_clk);
      c++;
    end
    #1;
    chk(tag, got_dat.size(), n);
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got_dat.size()) return got_dat[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [2:0] keep_at(input int i);
    if (i < got_keep.size()) return got_keep[i];
    return 3'd7;
  endfunction

  initial begin
    int base;
    int sent;
    int n;
    logic [7:0]  b;
    logic [31:0] exp_w;

    tests     = 0;
    failed    = 0;
    underflow = 0;
    res       = 1'b1;
    empty     = 1'b1;
    rdata     = 8'h00;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_keep", out_keep, 0);
    chk("rst_words_out", words_out, 0);
    step(2);
    res = 1'b0;
    step(2);

    // 1: one full word with out_ready high
    out_ready = 1'b1;
    chk("t1_rd_en_empty", rd_en, 0);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_words("t1_wait", 1, 30);
    chk("t1_data", got_at(0), 32'h44332211);
    chk("t1_keep", keep_at(0), 4);
    step(5);
    chk("t1_words_out", words_out, 1);
    chk("t1_count", got_dat.size(), 1);

    // 2: 12 beats against a stalled consumer
    out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) push(8'(i));
    step(30);
    chk("t2_valid_held", out_valid, 1);
    chk("t2_data_held", out_data, 32'h04030201);
    chk("t2_rd_en_stall", rd_en, 0);
    chk("t2_fifo_left", fq.size(), 4);
    out_ready = 1'b1;
    wait_words("t2_wait", 4, 60);
    chk("t2_w1", got_at(1), 32'h04030201);
    chk("t2_w2", got_at(2), 32'h08070605);
    chk("t2_w3", got_at(3), 32'h0C0B0A09);
    chk("t2_k3", keep_at(3), 4);
    step(3);
    chk("t2_words_out", words_out, 4);
    chk("t2_fifo_empty", fq.size(), 0);

    // 3: partial word forced out by flush, then flush with nothing held
    push(8'hA1); push(8'hA2);
    step(10);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    wait_words("t3_wait", 5, 20);
    chk("t3_data", got_at(4), 32'h0000A2A1);
    chk("t3_keep", keep_at(4), 2);
    step(3);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(10);
    chk("t3_no_empty_word", got_dat.size(), 5);
    chk("t3_words_out", words_out, 5);

    // 4: flush raised during the 4th pop completes the word normally
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    step(4);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    wait_words("t4_wait", 6, 20);
    chk("t4_data", got_at(5), 32'hB4B3B2B1);
    chk("t4_keep", keep_at(5), 4);
    step(10);
    chk("t4_no_extra", got_dat.size(), 6);

    // 5: async reset with a held word and a half-filled packer
    out_ready = 1'b0;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    step(15);
    push(8'hC1); push(8'hC2);
    step(10);
    chk("t5_pre_valid", out_valid, 1);
    @(negedge rd_clk);
    res = 1'b1;
    #1;
    chk("t5_async_valid", out_valid, 0);
    chk("t5_async_data", out_data, 0);
    chk("t5_async_keep", out_keep, 0);
    chk("t5_async_words", words_out, 0);
    chk("t5_async_rd_en", rd_en, 0);
    step(2);
    res = 1'b0;
    out_ready = 1'b1;
    push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
    wait_words("t5_wait", 7, 30);
    chk("t5_fresh", got_at(6), 32'hE4E3E2E1);
    chk("t5_keep", keep_at(6), 4);
    step(3);
    chk("t5_words_out", words_out, 1);

    // 6: 200 beats with random arrival and random out_ready
    base = got_dat.size();
    sent = 0;
    while (sent < 200) begin
      step(1);
      out_ready = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        if (sent < 200) begin
          push(8'(sent));
          sent++;
        end
      end
    end
    out_ready = 1'b1;
    wait_words("t6_wait", base + 50, 2000);
    for (int w = 0; w < 50; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(w * 4 + k);
        exp_w[k*8 +: 8] = b;
      end
      chk($sformatf("t6_w%0d", w), got_at(base + w), exp_w);
    end
    step(3);
    chk("t6_words_out", words_out, 51);
    chk("t6_underflow", underflow, 0);
    chk("t6_fifo_empty", fq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
